// File: rtl/chunked_adder_sequencer_pkg.sv
// chunked_adder_sequencer_pkg: shared chunk width and sequencer state encoding
package chunked_adder_sequencer_pkg;
  localparam int CHUNK_W = 3;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/chunked_adder_sequencer_if.sv
// chunked_adder_sequencer_if: start/operand request and valid/ready result bundle
interface chunked_adder_sequencer_if
  import chunked_adder_sequencer_pkg::*;
#(
  parameter int NUM_CHUNKS = 4
);
  localparam int W = CHUNK_W * NUM_CHUNKS;
  logic         inp_start;
  logic [W-1:0] inp_A;
  logic [W-1:0] inp_B;
  logic         inp_cin;
  logic         inp_ready;
  logic         out_busy;
  logic         out_valid;
  logic [W-1:0] out_S;
  logic         out_cout;
  modport master (
    output inp_start, inp_A, inp_B, inp_cin, inp_ready,
    input  out_busy, out_valid, out_S, out_cout
  );
  modport slave (
    input  inp_start, inp_A, inp_B, inp_cin, inp_ready,
    output out_busy, out_valid, out_S, out_cout
  );
endinterface

// File: rtl/three_bit_adder.sv
// three_bit_adder: combinational 3-bit full-adder stage shared across chunks
module three_bit_adder (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       cin,
  output logic [2:0] S,
  output logic       cout
);
  assign {cout, S} = {1'b0, A} + {1'b0, B} + {3'b000, cin};
endmodule

// File: rtl/chunked_adder_sequencer.sv
// chunked_adder_sequencer: W-bit add done one 3-bit chunk per clock, LSB chunk first
module chunked_adder_sequencer
  import chunked_adder_sequencer_pkg::*;
#(
  parameter int NUM_CHUNKS = 4
) (
  input logic inp_clk,
  input logic inp_rst_n,
  chunked_adder_sequencer_if.slave bus
);
  localparam int W = CHUNK_W * NUM_CHUNKS;
  localparam int CW = $clog2(NUM_CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic carry;
  logic [W-1:0] a_sr;
  logic [W-1:0] b_sr;
  logic [W-1:0] res;
  logic [CHUNK_W-1:0] s;
  logic co;
  logic [W-1:0] res_next;
  three_bit_adder u_stage (
    .A(a_sr[CHUNK_W-1:0]),
    .B(b_sr[CHUNK_W-1:0]),
    .cin(carry),
    .S(s),
    .cout(co)
  );
  // sum chunks enter at the top and shift down, so chunk k lands at bits [3k+2:3k] after the last shift
  assign res_next = {s, res[W-1:CHUNK_W]};
  always_ff @(posedge inp_clk or negedge inp_rst_n)
    if (!inp_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      bus.out_busy <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_S <= '0;
      bus.out_cout <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.inp_start) begin
            a_sr <= bus.inp_A;
            b_sr <= bus.inp_B;
            carry <= bus.inp_cin;
            cnt <= '0;
            bus.out_busy <= 1'b1;
            state <= RUN;
          end
        RUN: begin
          a_sr <= a_sr >> CHUNK_W;
          b_sr <= b_sr >> CHUNK_W;
          carry <= co;
          res <= res_next;
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            bus.out_S <= res_next;
            bus.out_cout <= co;
            bus.out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE:
          if (bus.inp_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_busy <= 1'b0;
            state <= IDLE;
          end
        default: begin
          bus.out_valid <= 1'b0;
          bus.out_busy <= 1'b0;
          cnt <= '0;
          state <= IDLE;
        end
      endcase
endmodule
